// File: rtl/axi_lite_xbar_map_ctrl.sv
// Address-map configuration controller for the AXI4-Lite crossbar. Software fills a shadow set
// that is copied atomically to the active set when no slave port holds an unserved AW/AR beat.
module axi_lite_xbar_map_ctrl #(
    parameter int unsigned NoSlvPorts    = 2,
    parameter int unsigned NoMstPorts    = 4,
    parameter int unsigned NoAddrRules   = 4,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned TimeoutCycles = 1024,
    // Same layout as axi_pkg::xbar_rule_32_t.
    parameter type rule_t = struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    },
    parameter int unsigned MstIdxWidth   = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   cfg_valid_i,
    output logic                                   cfg_ready_o,
    input  logic [1:0]                             cfg_sel_i,
    input  logic [7:0]                             cfg_idx_i,
    input  logic [AddrWidth-1:0]                   cfg_data_i,
    output logic                                   cfg_err_o,
    input  logic                                   commit_i,
    output logic                                   busy_o,
    output logic                                   commit_done_o,
    output logic                                   timeout_o,
    input  logic [NoSlvPorts-1:0]                  aw_valid_i,
    input  logic [NoSlvPorts-1:0]                  aw_ready_i,
    input  logic [NoSlvPorts-1:0]                  ar_valid_i,
    input  logic [NoSlvPorts-1:0]                  ar_ready_i,
    output rule_t [NoAddrRules-1:0]                addr_map_o,
    output logic [NoSlvPorts-1:0]                  en_default_mst_port_o,
    output logic [NoSlvPorts-1:0][MstIdxWidth-1:0] default_mst_port_o
);

    localparam int unsigned CntWidth      = $clog2(TimeoutCycles + 1);
    localparam int unsigned IdxFieldWidth = $bits(rule_t) - 2 * AddrWidth;
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(TimeoutCycles);

    localparam logic [1:0] SelStart   = 2'd0;
    localparam logic [1:0] SelEnd     = 2'd1;
    localparam logic [1:0] SelIdx     = 2'd2;
    localparam logic [1:0] SelDefault = 2'd3;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e state_q, state_d;

    rule_t [NoAddrRules-1:0]                shadow_map_q, shadow_map_d, active_map_q;
    logic [NoSlvPorts-1:0]                  shadow_en_q, shadow_en_d, active_en_q;
    logic [NoSlvPorts-1:0][MstIdxWidth-1:0] shadow_port_q, shadow_port_d, active_port_q;

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                timeout_q, timeout_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic quiet;
    logic cfg_fire;
    logic idx_in_range;
    logic commit_now;

    // A port is quiet when every pending address beat is handshaking this cycle.
    always_comb begin
        quiet = &((~aw_valid_i | aw_ready_i) & (~ar_valid_i | ar_ready_i));
    end

    always_comb begin
        cfg_ready_o = (state_q == StIdle);
        busy_o      = (state_q == StWait);
    end

    always_comb begin
        cfg_fire     = cfg_valid_i && cfg_ready_o;
        idx_in_range = (cfg_sel_i == SelDefault) ? (32'(cfg_idx_i) < NoSlvPorts)
                                                 : (32'(cfg_idx_i) < NoAddrRules);
        commit_now   = (state_q == StWait) && quiet;
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (commit_i) state_d = StWait;
            StWait:  if (quiet) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Shadow-set writes.
    always_comb begin
        shadow_map_d  = shadow_map_q;
        shadow_en_d   = shadow_en_q;
        shadow_port_d = shadow_port_q;
        if (cfg_fire && idx_in_range) begin
            for (int unsigned i = 0; i < NoAddrRules; i++) begin
                if (cfg_idx_i == 8'(i)) begin
                    case (cfg_sel_i)
                        SelStart: shadow_map_d[i].start_addr = cfg_data_i;
                        SelEnd:   shadow_map_d[i].end_addr   = cfg_data_i;
                        SelIdx:   shadow_map_d[i].idx =
                                      IdxFieldWidth'(cfg_data_i[MstIdxWidth-1:0]);
                        default: ;
                    endcase
                end
            end
            for (int unsigned p = 0; p < NoSlvPorts; p++) begin
                if ((cfg_sel_i == SelDefault) && (cfg_idx_i == 8'(p))) begin
                    shadow_en_d[p]   = cfg_data_i[0];
                    shadow_port_d[p] = cfg_data_i[MstIdxWidth:1];
                end
            end
        end
    end

    // Wait counter, sticky timeout and status pulses.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        done_d    = commit_now;
        err_d     = cfg_fire && !idx_in_range;
        if (commit_now) begin
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else if (state_q == StWait) begin
            if (cnt_q != CntMax) cnt_d = cnt_q + CntWidth'(1);
            if (cnt_d == CntMax) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_map_q  <= '0;
            shadow_en_q   <= '0;
            shadow_port_q <= '0;
            active_map_q  <= '0;
            active_en_q   <= '0;
            active_port_q <= '0;
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            shadow_map_q  <= shadow_map_d;
            shadow_en_q   <= shadow_en_d;
            shadow_port_q <= shadow_port_d;
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
            done_q        <= done_d;
            err_q         <= err_d;
            // No writes are accepted in WAIT, so the shadow is stable while a commit pends.
            if (commit_now) begin
                active_map_q  <= shadow_map_q;
                active_en_q   <= shadow_en_q;
                active_port_q <= shadow_port_q;
            end
        end
    end

    assign addr_map_o            = active_map_q;
    assign en_default_mst_port_o = active_en_q;
    assign default_mst_port_o    = active_port_q;
    assign commit_done_o         = done_q;
    assign cfg_err_o             = err_q;
    assign timeout_o             = timeout_q;

endmodule
